writeback_commit_unit_l3: RTL and testbench
===========================================

// Module: writeback_commit_unit_l3
// PURPOSE
//  Next-generation reordering writeback-commit unit. Collects results from p_num_pipes
//  execute pipes (X->W), broadcasts a completion notification for each accepted result,
//  and holds results in a parametrised reorder buffer (ROB) until they can commit in
//  seq_num order. New over the previous generation:
//  - configurable ROB depth, decoupled from the seq_num space;
//  - up to p_commit_width in-order commits per cycle;
//  - a squash port that discards younger in-flight results.
// PARAMETERS
//  p_num_pipes     1  number of X->W input pipes
//  p_seq_num_bits  5  width of seq_num; sequence space wraps modulo 2**p_seq_num_bits
//  p_rob_depth     8  ROB entries; power of 2, <= 2**p_seq_num_bits
//  p_commit_width  2  max commits per cycle; 1 <= p_commit_width <= p_rob_depth
// PORTS
//  clk              in   1                   clock
//  rst              in   1                   synchronous, active-high reset
//  Ex_val           in   [p_num_pipes]       pipe result valid
//  Ex_rdy           out  [p_num_pipes]       pipe result accepted when val&rdy
//  Ex_pc            in   [p_num_pipes]x32    instruction PC
//  Ex_seq_num       in   [p_num_pipes]xS     sequence number
//  Ex_waddr         in   [p_num_pipes]x5     destination register
//  Ex_wdata         in   [p_num_pipes]x32    writeback data
//  Ex_wen           in   [p_num_pipes]       register write enable
//  complete_val     out  1                   completion notification valid
//  complete_seq_num out  S                   seq_num of completed result
//  complete_waddr   out  5                   destination register
//  complete_wdata   out  32                  data, for bypass
//  complete_wen     out  1                   write enable
//  commit_val       out  [p_commit_width]    commit slot k valid; slots are contiguous from 0
//  commit_pc        out  [p_commit_width]x32 committed PC, slot 0 = oldest
//  commit_seq_num   out  [p_commit_width]xS  committed seq_num
//  commit_waddr     out  [p_commit_width]x5  committed destination register
//  commit_wdata     out  [p_commit_width]x32 committed data
//  commit_wen       out  [p_commit_width]    committed write enable
//  squash_val       in   1                   squash request
//  squash_seq_num   in   S                   oldest seq_num to discard
// BEHAVIOUR
//  Reset
//  - All ROB valid bits cleared; head_seq = 0; arbiter priority points at pipe 0.
//  - Reset has priority over every other event and aborts anything in flight.
//  - All *_val outputs are 0 during and the cycle after rst.
//  Accept
//  - Each cycle at most one pipe is granted, by round-robin among val pipes whose
//    ROB slot (seq_num mod p_rob_depth) is free.
//  - Ex_rdy[i] = grant[i]; rdy never depends on the pipe's own val, apart from arbitration.
//  - Priority rotates to the pipe after the granted one on each accept.
//  Complete
//  - Combinational, same cycle as the accept: complete_val = |(Ex_val & Ex_rdy), with the
//    granted pipe's fields.
//  Writeback into the ROB
//  - The accepted result is written at the clock edge.
//  - It can commit no earlier than the following cycle (min accept->commit latency 1).
//  Commit
//  - Driven combinationally from ROB registers.
//  - Slot k is valid iff entries head_seq..head_seq+k are all valid (in-order prefix,
//    at most p_commit_width).
//  - At the edge, committed entries are cleared and head_seq += n_committed, with
//    seq_num arithmetic mod 2**S.
//  - No commit backpressure.
//  Slot freeing
//  - A slot freed by commit in cycle t is writable from cycle t+1. Same-cycle
//    commit + write to the same slot is not allowed; rdy is computed from current valid bits.
//  Squash
//  - Discard set: entries whose age (seq - head_seq) mod 2**S >= (squash_seq_num - head_seq) mod 2**S.
//  - Squash has priority over commit: commit_val = 0 in the squash cycle.
//  - In the squash cycle, Ex_rdy and complete_val are 0.
//  - squash_seq_num == head_seq flushes the whole ROB; head_seq is unchanged.
//  Boundaries
//  - ROB full: all occupied slots block rdy for aliased seq_nums.
//  - Empty: commit_val = 0.
//  - head_seq wrap-around from 2**S-1 to 0 is seamless.
// STRUCTURE
//  Package writeback_commit_pkg:
//  - t_rob_entry {pc, seq_num, waddr, wdata, wen}
//  - function seq_age(seq, head) returning (seq - head) mod 2**S.
//  Sub-module rr_arbiter #(p_num_pipes): req -> one-hot grant, priority pointer updated
//  on en. The ROB array, head counter and commit prefix logic stay in this module.
//  trace() function: the granted pipe, head_seq, commit count.
// TESTING
//  1. Single pipe, in-order seq 0,1,2
//     -> complete in the accept cycle; commits 0,1,2 each one cycle after accept.
//  2. Out of order, p_commit_width=2: send seq 2,1, then 0
//     -> no commit until 0 is present; then cycle N commits {0,1}, cycle N+1 commits {2}.
//  3. Two pipes, both val every cycle
//     -> grants alternate 0,1,0,1; all commits in seq order.
//  4. p_rob_depth=4: fill seq 1..4 with head 0 blocked
//     -> seq 4 (aliases slot 0) sees rdy=0 until seq 0 arrives and commits.
//  5. S=3 wrap: stream seq 6,7,0,1
//     -> commits 6,7,0,1 with head wrapping 7->0.
//  6. Squash: ROB holds 3,4,5 (head 3 missing); squash_seq_num=4
//     -> 4,5 cleared, commit_val=0 in the squash cycle; re-sent 3 commits alone.

Source files
------------

// File: rtl/writeback_commit_unit_l3_pkg.sv
// Shared types and sequence-number helpers for the reordering writeback-commit unit.
package writeback_commit_pkg;

  localparam int unsigned SEQ_STORE_BITS = 32;

  typedef struct packed {
    logic [31:0]               pc;
    logic [SEQ_STORE_BITS-1:0] seq_num;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
  } t_rob_entry;

  // Distance of seq from head in a sequence space of 2**bits.
  function automatic logic [SEQ_STORE_BITS-1:0] seq_age(input logic [31:0] seq,
                                                         input logic [31:0] head,
                                                         input int unsigned bits);
    logic [31:0] mask;
    mask = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
    return (seq - head) & mask;
  endfunction

endpackage

// File: rtl/writeback_commit_unit_l3_arb.sv
// Round-robin arbiter: one-hot grant among requesters, priority moves past the winner on en.
module rr_arbiter #(
  parameter  int unsigned p_num_pipes = 1,
  localparam int unsigned GW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_num_pipes-1:0] req,
  input  logic                   en,
  output logic [p_num_pipes-1:0] grant,
  output logic [GW-1:0]          grant_idx
);

  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      idx = GW'((32'(ptr_q) + i) % p_num_pipes);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = ptr_q;
    if (en && found) begin
      ptr_d = ((32'(grant_idx) + 32'd1) == p_num_pipes) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/writeback_commit_unit_l3.sv
// Reordering writeback-commit unit: accepts X->W results, broadcasts completion,
// and commits up to p_commit_width results per cycle in seq_num order.
module writeback_commit_unit_l3
  import writeback_commit_pkg::*;
#(
  parameter int unsigned p_num_pipes    = 1,
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_rob_depth    = 8,
  parameter int unsigned p_commit_width = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                Ex_val,
  output logic [p_num_pipes-1:0]                Ex_rdy,
  input  logic [p_num_pipes*32-1:0]             Ex_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] Ex_seq_num,
  input  logic [p_num_pipes*5-1:0]              Ex_waddr,
  input  logic [p_num_pipes*32-1:0]             Ex_wdata,
  input  logic [p_num_pipes-1:0]                Ex_wen,
  output logic                                  complete_val,
  output logic [p_seq_num_bits-1:0]             complete_seq_num,
  output logic [4:0]                            complete_waddr,
  output logic [31:0]                           complete_wdata,
  output logic                                  complete_wen,
  output logic [p_commit_width-1:0]             commit_val,
  output logic [p_commit_width*32-1:0]          commit_pc,
  output logic [p_commit_width*p_seq_num_bits-1:0] commit_seq_num,
  output logic [p_commit_width*5-1:0]           commit_waddr,
  output logic [p_commit_width*32-1:0]          commit_wdata,
  output logic [p_commit_width-1:0]             commit_wen,
  input  logic                                  squash_val,
  input  logic [p_seq_num_bits-1:0]             squash_seq_num
);

  localparam int unsigned NP = p_num_pipes;
  localparam int unsigned S  = p_seq_num_bits;
  localparam int unsigned D  = p_rob_depth;
  localparam int unsigned W  = p_commit_width;
  localparam int unsigned GW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CW = $clog2(W + 1);

  t_rob_entry    rob_q [D];
  t_rob_entry    rob_d [D];
  logic [D-1:0]  valid_q, valid_d;
  logic [S-1:0]  head_q, head_d;
  logic          rst_q, rst_d;

  logic [NP-1:0] req, grant;
  logic [GW-1:0] grant_idx;
  logic          accept, blocked, run;
  logic [IW-1:0] in_slot [NP];
  logic [IW-1:0] c_slot  [W];
  logic [CW-1:0] n_commit;
  logic [31:0]   sq_age;
  t_rob_entry    wr_entry;

  // A pipe may only be granted if its seq lies inside the ROB window, so an aliased
  // younger seq can never steal the slot still owed to an older one.
  always_comb begin
    blocked = rst | rst_q | squash_val;
    req     = '0;
    in_slot = '{default: '0};
    for (int unsigned i = 0; i < NP; i++) begin
      in_slot[i] = IW'(32'(Ex_seq_num[i*S +: S]) % D);
      req[i]     = Ex_val[i] & ~blocked & ~valid_q[in_slot[i]] &
                   (seq_age(32'(Ex_seq_num[i*S +: S]), 32'(head_q), S) < D);
    end
  end

  rr_arbiter #(.p_num_pipes(NP)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    accept           = |grant;
    Ex_rdy           = grant;
    complete_val     = accept;
    complete_seq_num = Ex_seq_num[grant_idx*S +: S];
    complete_waddr   = Ex_waddr[grant_idx*5 +: 5];
    complete_wdata   = Ex_wdata[grant_idx*32 +: 32];
    complete_wen     = Ex_wen[grant_idx];
    wr_entry         = '{pc:      Ex_pc[grant_idx*32 +: 32],
                         seq_num: 32'(Ex_seq_num[grant_idx*S +: S]),
                         waddr:   Ex_waddr[grant_idx*5 +: 5],
                         wdata:   Ex_wdata[grant_idx*32 +: 32],
                         wen:     Ex_wen[grant_idx]};
  end

  always_comb begin
    run            = ~blocked;
    n_commit       = '0;
    commit_val     = '0;
    commit_pc      = '0;
    commit_seq_num = '0;
    commit_waddr   = '0;
    commit_wdata   = '0;
    commit_wen     = '0;
    c_slot         = '{default: '0};
    for (int unsigned k = 0; k < W; k++) begin
      c_slot[k]              = IW'((32'(head_q) + k) % D);
      run                    = run & valid_q[c_slot[k]];
      commit_val[k]          = run;
      n_commit               = n_commit + CW'(run);
      commit_pc[k*32 +: 32]  = rob_q[c_slot[k]].pc;
      commit_seq_num[k*S +: S] = rob_q[c_slot[k]].seq_num[S-1:0];
      commit_waddr[k*5 +: 5] = rob_q[c_slot[k]].waddr;
      commit_wdata[k*32 +: 32] = rob_q[c_slot[k]].wdata;
      commit_wen[k]          = rob_q[c_slot[k]].wen;
    end
  end

  always_comb begin
    rst_d   = rst;
    valid_d = valid_q;
    rob_d   = rob_q;
    head_d  = head_q + S'(n_commit);
    sq_age  = seq_age(32'(squash_seq_num), 32'(head_q), S);
    for (int unsigned k = 0; k < W; k++) begin
      if (commit_val[k]) valid_d[c_slot[k]] = 1'b0;
    end
    if (squash_val) begin
      for (int unsigned e = 0; e < D; e++) begin
        if (seq_age(rob_q[e].seq_num, 32'(head_q), S) >= sq_age) valid_d[e] = 1'b0;
      end
    end
    if (accept) begin
      rob_d[in_slot[grant_idx]]   = wr_entry;
      valid_d[in_slot[grant_idx]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst_d;
    rob_q <= rob_d;
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  function automatic logic [95:0] trace();
    return {32'(grant_idx), 32'(head_q), 32'(n_commit)};
  endfunction

endmodule

// File: tb/tb_writeback_commit_unit_l3.sv
// Directed bench for writeback_commit_unit_l3 with 2 pipes, 3-bit seq space, 4-entry ROB.
module tb_writeback_commit_unit_l3;

  localparam int unsigned NP = 2;
  localparam int unsigned S  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned W  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   Ex_val = '0;
  logic [NP-1:0]   Ex_rdy;
  logic [NP*32-1:0] Ex_pc = '0;
  logic [NP*S-1:0] Ex_seq_num = '0;
  logic [NP*5-1:0] Ex_waddr = '0;
  logic [NP*32-1:0] Ex_wdata = '0;
  logic [NP-1:0]   Ex_wen = '0;
  logic            complete_val;
  logic [S-1:0]    complete_seq_num;
  logic [4:0]      complete_waddr;
  logic [31:0]     complete_wdata;
  logic            complete_wen;
  logic [W-1:0]    commit_val;
  logic [W*32-1:0] commit_pc;
  logic [W*S-1:0]  commit_seq_num;
  logic [W*5-1:0]  commit_waddr;
  logic [W*32-1:0] commit_wdata;
  logic [W-1:0]    commit_wen;
  logic            squash_val = 1'b0;
  logic [S-1:0]    squash_seq_num = '0;

  int vectors = 0;
  int miscompares = 0;

  writeback_commit_unit_l3 #(
    .p_num_pipes(NP), .p_seq_num_bits(S), .p_rob_depth(D), .p_commit_width(W)
  ) dut (
    .clk(clk), .rst(rst),
    .Ex_val(Ex_val), .Ex_rdy(Ex_rdy), .Ex_pc(Ex_pc), .Ex_seq_num(Ex_seq_num),
    .Ex_waddr(Ex_waddr), .Ex_wdata(Ex_wdata), .Ex_wen(Ex_wen),
    .complete_val(complete_val), .complete_seq_num(complete_seq_num),
    .complete_waddr(complete_waddr), .complete_wdata(complete_wdata),
    .complete_wen(complete_wen),
    .commit_val(commit_val), .commit_pc(commit_pc), .commit_seq_num(commit_seq_num),
    .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .commit_wen(commit_wen),
    .squash_val(squash_val), .squash_seq_num(squash_seq_num)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(input logic [2:0] s);
    return 32'h0000_1000 + 32'({s, 2'b00});
  endfunction
  function automatic logic [31:0] data_of(input logic [2:0] s);
    return 32'hCAFE_0000 + 32'(s);
  endfunction
  function automatic logic [4:0] waddr_of(input logic [2:0] s);
    return 5'(s) + 5'd1;
  endfunction
  function automatic logic wen_of(input logic [2:0] s);
    return ~s[0];
  endfunction

  task automatic set_pipe(input int p, input logic v, input logic [2:0] s);
    Ex_val[p]             = v;
    Ex_pc[p*32 +: 32]     = pc_of(s);
    Ex_seq_num[p*S +: S]  = s;
    Ex_waddr[p*5 +: 5]    = waddr_of(s);
    Ex_wdata[p*32 +: 32]  = data_of(s);
    Ex_wen[p]             = wen_of(s);
  endtask

  task automatic clear_inputs();
    Ex_val         = '0;
    squash_val     = 1'b0;
    squash_seq_num = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; clear_inputs();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; clear_inputs(); set_pipe(0, 1'b1, 3'd0); #1;
    vectors++; if (Ex_rdy !== 2'b00) begin miscompares++; $display("FAIL rst_rdy got=%b exp=00", Ex_rdy); end
    vectors++; if (complete_val !== 1'b0) begin miscompares++; $display("FAIL rst_cval got=%b exp=0", complete_val); end
    vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL rst_commit got=%b exp=00", commit_val); end
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if (Ex_rdy !== 2'b00) begin miscompares++; $display("FAIL post_rst_rdy got=%b exp=00", Ex_rdy); end
    vectors++; if (complete_val !== 1'b0) begin miscompares++; $display("FAIL post_rst_cval got=%b exp=0", complete_val); end
    vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL post_rst_commit got=%b exp=00", commit_val); end
    @(negedge clk); #1;
    vectors++; if (Ex_rdy !== 2'b01) begin miscompares++; $display("FAIL rst_first_rdy got=%b exp=01", Ex_rdy); end
    @(negedge clk); clear_inputs(); #1;
    vectors++; if (commit_val !== 2'b01) begin miscompares++; $display("FAIL rst_first_commit got=%b exp=01", commit_val); end
  endtask

  task automatic test_in_order();
    logic [2:0] s;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      s = 3'(c);
      if (c < 3) set_pipe(0, 1'b1, s);
      #1;
      if (c < 3) begin
        vectors++; if (Ex_rdy !== 2'b01) begin miscompares++; $display("FAIL io_rdy c=%0d got=%b exp=01", c, Ex_rdy); end
        vectors++; if (complete_val !== 1'b1 || complete_seq_num !== s) begin miscompares++; $display("FAIL io_complete c=%0d got=%b/%0d exp=1/%0d", c, complete_val, complete_seq_num, s); end
        vectors++; if (complete_waddr !== waddr_of(s) || complete_wdata !== data_of(s) || complete_wen !== wen_of(s)) begin miscompares++; $display("FAIL io_cfields c=%0d got=%h/%h/%b exp=%h/%h/%b", c, complete_waddr, complete_wdata, complete_wen, waddr_of(s), data_of(s), wen_of(s)); end
      end
      if (c == 0) begin
        vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL io_commit0 got=%b exp=00", commit_val); end
      end else begin
        s = 3'(c - 1);
        vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== s) begin miscompares++; $display("FAIL io_commit c=%0d got=%b/%0d exp=01/%0d", c, commit_val, commit_seq_num[2:0], s); end
        vectors++; if (commit_pc[31:0] !== pc_of(s) || commit_wdata[31:0] !== data_of(s) || commit_waddr[4:0] !== waddr_of(s)) begin miscompares++; $display("FAIL io_cmfields c=%0d got=%h/%h/%h exp=%h/%h/%h", c, commit_pc[31:0], commit_wdata[31:0], commit_waddr[4:0], pc_of(s), data_of(s), waddr_of(s)); end
      end
      @(negedge clk);
    end
    #1;
    vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL io_empty got=%b exp=00", commit_val); end
  endtask

  task automatic test_out_of_order();
    logic [2:0] order [3] = '{3'd2, 3'd1, 3'd0};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs(); set_pipe(0, 1'b1, order[c]); #1;
      vectors++; if (Ex_rdy !== 2'b01) begin miscompares++; $display("FAIL ooo_rdy c=%0d got=%b exp=01", c, Ex_rdy); end
      vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL ooo_hold c=%0d got=%b exp=00", c, commit_val); end
      @(negedge clk);
    end
    clear_inputs(); #1;
    vectors++; if (commit_val !== 2'b11 || commit_seq_num !== 6'b001_000) begin miscompares++; $display("FAIL ooo_pair got=%b/%b exp=11/001000", commit_val, commit_seq_num); end
    vectors++; if (commit_wdata[63:32] !== data_of(3'd1)) begin miscompares++; $display("FAIL ooo_slot1_data got=%h exp=%h", commit_wdata[63:32], data_of(3'd1)); end
    @(negedge clk); #1;
    vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'd2) begin miscompares++; $display("FAIL ooo_last got=%b/%0d exp=01/2", commit_val, commit_seq_num[2:0]); end
    @(negedge clk); #1;
    vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL ooo_empty got=%b exp=00", commit_val); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      set_pipe(0, 1'b1, 3'(c + (c % 2)));
      set_pipe(1, 1'b1, 3'(c + 1 - (c % 2)));
      exp_rdy = (c % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      vectors++; if (Ex_rdy !== exp_rdy) begin miscompares++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, Ex_rdy, exp_rdy); end
      vectors++; if (complete_seq_num !== 3'(c)) begin miscompares++; $display("FAIL b2b_cseq c=%0d got=%0d exp=%0d", c, complete_seq_num, c); end
      if (c > 0) begin
        vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'(c - 1)) begin miscompares++; $display("FAIL b2b_commit c=%0d got=%b/%0d exp=01/%0d", c, commit_val, commit_seq_num[2:0], c - 1); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rob_full();
    do_reset();
    for (int c = 1; c < 4; c++) begin
      clear_inputs(); set_pipe(0, 1'b1, 3'(c)); #1;
      vectors++; if (Ex_rdy !== 2'b01 || commit_val !== 2'b00) begin miscompares++; $display("FAIL full_fill c=%0d got=%b/%b exp=01/00", c, Ex_rdy, commit_val); end
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      clear_inputs(); set_pipe(0, 1'b1, 3'd4); #1;
      vectors++; if (Ex_rdy !== 2'b00 || complete_val !== 1'b0) begin miscompares++; $display("FAIL full_alias c=%0d got=%b/%b exp=00/0", c, Ex_rdy, complete_val); end
      @(negedge clk);
    end
    set_pipe(1, 1'b1, 3'd0); #1;
    vectors++; if (Ex_rdy !== 2'b10 || complete_seq_num !== 3'd0) begin miscompares++; $display("FAIL full_head got=%b/%0d exp=10/0", Ex_rdy, complete_seq_num); end
    @(negedge clk); Ex_val[1] = 1'b0; #1;
    vectors++; if (Ex_rdy !== 2'b00 || commit_val !== 2'b11 || commit_seq_num !== 6'b001_000) begin miscompares++; $display("FAIL full_drain1 got=%b/%b/%b exp=00/11/001000", Ex_rdy, commit_val, commit_seq_num); end
    @(negedge clk); #1;
    vectors++; if (Ex_rdy !== 2'b01 || complete_seq_num !== 3'd4) begin miscompares++; $display("FAIL full_alias_ok got=%b/%0d exp=01/4", Ex_rdy, complete_seq_num); end
    vectors++; if (commit_val !== 2'b11 || commit_seq_num !== 6'b011_010) begin miscompares++; $display("FAIL full_drain2 got=%b/%b exp=11/011010", commit_val, commit_seq_num); end
    @(negedge clk); clear_inputs(); #1;
    vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'd4) begin miscompares++; $display("FAIL full_alias_commit got=%b/%0d exp=01/4", commit_val, commit_seq_num[2:0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_inputs(); set_pipe(0, 1'b1, 3'(c)); #1;
      vectors++; if (Ex_rdy !== 2'b01) begin miscompares++; $display("FAIL wrap_rdy c=%0d got=%b exp=01", c, Ex_rdy); end
      if (c >= 5) begin
        vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'(c - 1)) begin miscompares++; $display("FAIL wrap_commit c=%0d got=%b/%0d exp=01/%0d", c, commit_val, commit_seq_num[2:0], (c - 1) % 8); end
      end
      @(negedge clk);
    end
    clear_inputs(); #1;
    vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'd1) begin miscompares++; $display("FAIL wrap_last got=%b/%0d exp=01/1", commit_val, commit_seq_num[2:0]); end
  endtask

  task automatic test_squash();
    logic [2:0] stream [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_inputs(); set_pipe(0, 1'b1, stream[c]); #1;
      vectors++; if (Ex_rdy !== 2'b01) begin miscompares++; $display("FAIL sq_fill c=%0d got=%b exp=01", c, Ex_rdy); end
      @(negedge clk);
    end
    #1;
    vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL sq_gap got=%b exp=00", commit_val); end
    squash_val = 1'b1; squash_seq_num = 3'd4; set_pipe(0, 1'b1, 3'd3); #1;
    vectors++; if (Ex_rdy !== 2'b00 || complete_val !== 1'b0 || commit_val !== 2'b00) begin miscompares++; $display("FAIL sq_cycle got=%b/%b/%b exp=00/0/00", Ex_rdy, complete_val, commit_val); end
    @(negedge clk); squash_val = 1'b0; #1;
    vectors++; if (Ex_rdy !== 2'b01 || complete_seq_num !== 3'd3 || commit_val !== 2'b00) begin miscompares++; $display("FAIL sq_resend got=%b/%0d/%b exp=01/3/00", Ex_rdy, complete_seq_num, commit_val); end
    @(negedge clk); clear_inputs(); #1;
    vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'd3) begin miscompares++; $display("FAIL sq_alone got=%b/%0d exp=01/3", commit_val, commit_seq_num[2:0]); end
    @(negedge clk); set_pipe(0, 1'b1, 3'd5); #1;
    vectors++; if (commit_val !== 2'b00 || Ex_rdy !== 2'b01) begin miscompares++; $display("FAIL sq_cleared got=%b/%b exp=00/01", commit_val, Ex_rdy); end
    @(negedge clk); set_pipe(0, 1'b1, 3'd6); #1;
    @(negedge clk); clear_inputs(); squash_val = 1'b1; squash_seq_num = 3'd4; #1;
    vectors++; if (commit_val !== 2'b00) begin miscompares++; $display("FAIL sq_flush_cycle got=%b exp=00", commit_val); end
    @(negedge clk); clear_inputs(); set_pipe(0, 1'b1, 3'd4); #1;
    vectors++; if (Ex_rdy !== 2'b01 || commit_val !== 2'b00) begin miscompares++; $display("FAIL sq_flush_head got=%b/%b exp=01/00", Ex_rdy, commit_val); end
    @(negedge clk); clear_inputs(); #1;
    vectors++; if (commit_val !== 2'b01 || commit_seq_num[2:0] !== 3'd4) begin miscompares++; $display("FAIL sq_flush_all got=%b/%0d exp=01/4", commit_val, commit_seq_num[2:0]); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_back_to_back();
    test_rob_full();
    test_wrap();
    test_squash();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
